truth_table_checker: RTL and testbench

- Sequential response checker for our small combinational function blocks. It sweeps every input vector into up to N_IMP implementations of the same function (structural, dataflow, simplified) and samples each implementation's output.
- It builds one truth table per implementation, flags every vector where the implementations disagree, and reports an equivalence verdict.
- It replaces the hand-read $display sweep with a synthesizable, self-checking reader of the function outputs.

---
 rtl/truth_table_checker.sv | 90 +++++++++
 tb/tb_truth_table_checker.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// Sweeps every input vector into N_IMP implementations of one function and
// records each truth table, per-vector disagreements and an equivalence verdict.
module truth_table_checker #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned N_IMP  = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic [N_IN-1:0]               vec_out,
  input  logic [N_IMP-1:0]              f_in,
  output logic                          busy,
  output logic                          done,
  output logic [N_IMP*(2**N_IN)-1:0]    tt_out,
  output logic [(2**N_IN)-1:0]          mismatch,
  output logic [N_IN:0]                 err_count,
  output logic                          equiv
);

  localparam int unsigned V  = 2**N_IN;
  localparam int unsigned HW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, DONE} state_t;

  state_t          state;
  logic [HW-1:0]   hold_cnt;
  logic            disagree;

  // Implementations disagree unless their outputs are all ones or all zeros.
  always_comb begin
    disagree = 1'b0;
    disagree = (|f_in) & ~(&f_in);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vec_out   <= '0;
      hold_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tt_out    <= '0;
      mismatch  <= '0;
      err_count <= '0;
      equiv     <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tt_out    <= '0;
            mismatch  <= '0;
            err_count <= '0;
            vec_out   <= '0;
            hold_cnt  <= HW'(SETTLE);
            busy      <= 1'b1;
            state     <= (SETTLE == 0) ? SAMPLE : HOLD;
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt - 1'b1;
          if (hold_cnt == HW'(1)) state <= SAMPLE;
        end
        SAMPLE: begin
          for (int unsigned i = 0; i < N_IMP; i++) begin
            tt_out[i*V + vec_out] <= f_in[i];
          end
          mismatch[vec_out] <= disagree;
          if (disagree) err_count <= err_count + 1'b1;
          if (vec_out == '1) begin
            state <= DONE;
          end else begin
            vec_out  <= vec_out + 1'b1;
            hold_cnt <= HW'(SETTLE);
            state    <= (SETTLE == 0) ? SAMPLE : HOLD;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          equiv <= (err_count == '0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: a SETTLE=1 and a SETTLE=0 instance driven from
// per-implementation truth tables, checked against a table-level model.
module tb_truth_table_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [3:0]  vec_a, vec_b;
  logic [2:0]  f_a, f_b;
  logic        busy_a, busy_b, done_a, done_b, eq_a, eq_b;
  logic [47:0] tt_a, tt_b;
  logic [15:0] mm_a, mm_b;
  logic [4:0]  ec_a, ec_b;
  logic [15:0] tbl [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    f_a = '0;
    f_b = '0;
    for (int i = 0; i < 3; i++) begin
      f_a[i] = tbl[i][vec_a];
      f_b[i] = tbl[i][vec_b];
    end
  end

  truth_table_checker #(.N_IN(4), .N_IMP(3), .SETTLE(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .vec_out(vec_a), .f_in(f_a),
    .busy(busy_a), .done(done_a), .tt_out(tt_a), .mismatch(mm_a),
    .err_count(ec_a), .equiv(eq_a));

  truth_table_checker #(.N_IN(4), .N_IMP(3), .SETTLE(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .vec_out(vec_b), .f_in(f_b),
    .busy(busy_b), .done(done_b), .tt_out(tt_b), .mismatch(mm_b),
    .err_count(ec_b), .equiv(eq_b));

  // b | ~d over vectors k = {a,b,c,d}
  function automatic logic [15:0] bd_func();
    logic [15:0] r;
    for (int k = 0; k < 16; k++) r[k] = (((k >> 2) & 1) | ((k & 1) ^ 1)) != 0;
    return r;
  endfunction

  function automatic logic [47:0] model_tt();
    return {tbl[2], tbl[1], tbl[0]};
  endfunction

  function automatic logic [15:0] model_mm();
    logic [15:0] r;
    for (int k = 0; k < 16; k++) begin
      int ones = 0;
      for (int i = 0; i < 3; i++) ones += int'(tbl[i][k]);
      r[k] = (ones != 0) && (ones != 3);
    end
    return r;
  endfunction

  function automatic logic [4:0] model_err();
    logic [15:0] m = model_mm();
    int n = 0;
    for (int k = 0; k < 16; k++) n += int'(m[k]);
    return 5'(n);
  endfunction

  // Pulses start on one instance and observes edges 1..last: first done edge,
  // number of done pulses, and vec_out deviations from the held-vector schedule.
  task automatic sweep(input bit sel, input int last, input int re1, input int re2,
                       output int done_edge, output int pulses, output int vec_bad);
    int s = sel ? 0 : 1;
    int ev;
    done_edge = -1; pulses = 0; vec_bad = 0;
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    if (sel) start_b = (re1 == 1 || re2 == 1); else start_a = (re1 == 1 || re2 == 1);
    for (int n = 1; n <= last; n++) begin
      @(posedge clk); #1;
      if (sel ? done_b : done_a) begin
        pulses++;
        if (done_edge < 0) done_edge = n;
      end
      ev = n / (s + 1);
      if (ev > 15) ev = 15;
      if ((sel ? vec_b : vec_a) !== 4'(ev)) vec_bad++;
      if (sel) start_b = (n + 1 == re1 || n + 1 == re2);
      else     start_a = (n + 1 == re1 || n + 1 == re2);
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({vec_a, busy_a, done_a} !== 6'b0) begin errors++; $display("FAIL reset_ctl_a got %h exp 0", {vec_a, busy_a, done_a}); end
    checks++; if ({tt_a, mm_a, ec_a} !== '0) begin errors++; $display("FAIL reset_res_a got %h exp 0", {tt_a, mm_a, ec_a}); end
    checks++; if (eq_a !== 1'b1) begin errors++; $display("FAIL reset_eq_a got %b exp 1", eq_a); end
    checks++; if ({vec_b, busy_b, done_b, tt_b, mm_b, ec_b, eq_b} !== {75'b0, 1'b1}) begin errors++; $display("FAIL reset_b got %h", {vec_b, busy_b, done_b, tt_b, mm_b, ec_b, eq_b}); end
    rst = 1'b0;
  endtask

  task automatic test_all_equal();
    int de, pu, vb;
    for (int i = 0; i < 3; i++) tbl[i] = bd_func();
    sweep(0, 36, -1, -1, de, pu, vb);
    checks++; if (de !== 33) begin errors++; $display("FAIL eq_done_edge got %0d exp 33", de); end
    checks++; if (pu !== 1) begin errors++; $display("FAIL eq_done_pulses got %0d exp 1", pu); end
    checks++; if (vb !== 0) begin errors++; $display("FAIL eq_vec_seq got %0d bad exp 0", vb); end
    checks++; if (tt_a !== {3{16'hF5F5}}) begin errors++; $display("FAIL eq_tt got %h exp %h", tt_a, {3{16'hF5F5}}); end
    checks++; if ({mm_a, ec_a, eq_a, busy_a} !== {16'h0, 5'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL eq_verdict got %h %0d %b %b", mm_a, ec_a, eq_a, busy_a); end
  endtask

  task automatic test_stuck();
    int de, pu, vb;
    tbl[0] = bd_func(); tbl[1] = bd_func(); tbl[2] = 16'h0000;
    sweep(0, 34, -1, -1, de, pu, vb);
    checks++; if (tt_a[47:32] !== 16'h0000) begin errors++; $display("FAIL stuck_tt2 got %h exp 0000", tt_a[47:32]); end
    checks++; if (mm_a !== 16'hF5F5) begin errors++; $display("FAIL stuck_mm got %h exp F5F5", mm_a); end
    checks++; if (ec_a !== 5'd12) begin errors++; $display("FAIL stuck_err got %0d exp 12", ec_a); end
    checks++; if (eq_a !== 1'b0) begin errors++; $display("FAIL stuck_equiv got %b exp 0", eq_a); end
  endtask

  task automatic test_single_flip();
    int de, pu, vb;
    tbl[0] = bd_func(); tbl[1] = bd_func() ^ 16'h0200; tbl[2] = bd_func();
    sweep(0, 34, -1, -1, de, pu, vb);
    checks++; if (tt_a[31:16] !== 16'hF7F5) begin errors++; $display("FAIL flip_tt1 got %h exp F7F5", tt_a[31:16]); end
    checks++; if (mm_a !== 16'h0200) begin errors++; $display("FAIL flip_mm got %h exp 0200", mm_a); end
    checks++; if ({ec_a, eq_a} !== {5'd1, 1'b0}) begin errors++; $display("FAIL flip_verdict got %0d %b exp 1 0", ec_a, eq_a); end
  endtask

  task automatic test_back_to_back();
    int de, pu, vb, n;
    logic seen;
    tbl[0] = bd_func(); tbl[1] = bd_func(); tbl[2] = 16'h0000;
    sweep(0, 34, 5, 33, de, pu, vb);
    checks++; if (de !== 33 || pu !== 1) begin errors++; $display("FAIL b2b_done got edge %0d pulses %0d exp 33 1", de, pu); end
    checks++; if (vb !== 0) begin errors++; $display("FAIL b2b_vec_seq got %0d bad exp 0", vb); end
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    checks++; if ({busy_a, tt_a, mm_a, ec_a} !== {1'b1, 69'b0}) begin errors++; $display("FAIL b2b_restart got busy %b tt %h mm %h err %0d", busy_a, tt_a, mm_a, ec_a); end
    seen = 1'b0;
    for (n = 0; n < 60 && !seen; n++) begin
      @(posedge clk); #1;
      seen = done_a;
    end
    checks++; if (!seen) begin errors++; $display("FAIL b2b_second_done got none exp pulse"); end
    checks++; if ({tt_a, mm_a, ec_a, eq_a} !== {model_tt(), model_mm(), model_err(), model_err() == 0}) begin errors++; $display("FAIL b2b_results got %h %h %0d exp %h %h %0d", tt_a, mm_a, ec_a, model_tt(), model_mm(), model_err()); end
  endtask

  task automatic test_mid_reset();
    int de, pu, vb;
    logic found;
    for (int i = 0; i < 3; i++) tbl[i] = bd_func();
    tbl[2] = 16'h1234;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(posedge clk); #1;
      found = (vec_a == 4'd7);
    end
    checks++; if (!found) begin errors++; $display("FAIL midrst_reach7 got vec %0d exp 7", vec_a); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({vec_a, busy_a, done_a, tt_a, mm_a, ec_a, eq_a} !== {75'b0, 1'b1}) begin errors++; $display("FAIL midrst_values got vec %0d busy %b tt %h mm %h err %0d eq %b", vec_a, busy_a, tt_a, mm_a, ec_a, eq_a); end
    rst = 1'b0;
    tbl[2] = bd_func();
    sweep(0, 34, -1, -1, de, pu, vb);
    checks++; if (de !== 33 || vb !== 0) begin errors++; $display("FAIL midrst_sweep got edge %0d badvec %0d exp 33 0", de, vb); end
    checks++; if ({tt_a, mm_a, ec_a, eq_a} !== {{3{16'hF5F5}}, 16'h0, 5'd0, 1'b1}) begin errors++; $display("FAIL midrst_results got %h %h %0d %b", tt_a, mm_a, ec_a, eq_a); end
  endtask

  task automatic test_settle0();
    int de, pu, vb;
    for (int i = 0; i < 3; i++) tbl[i] = bd_func();
    sweep(1, 20, -1, -1, de, pu, vb);
    checks++; if (de !== 17 || pu !== 1) begin errors++; $display("FAIL s0_done got edge %0d pulses %0d exp 17 1", de, pu); end
    checks++; if (vb !== 0) begin errors++; $display("FAIL s0_vec_seq got %0d bad exp 0", vb); end
    checks++; if ({tt_b, mm_b, ec_b, eq_b} !== {{3{16'hF5F5}}, 16'h0, 5'd0, 1'b1}) begin errors++; $display("FAIL s0_results got %h %h %0d %b", tt_b, mm_b, ec_b, eq_b); end
  endtask

  task automatic test_random();
    int de, pu, vb, exp_edge;
    bit sel;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 3; i++) tbl[i] = 16'($urandom);
      if (it == 0) begin tbl[1] = tbl[0]; tbl[2] = tbl[0]; end
      if (it == 1) begin tbl[1] = tbl[0]; tbl[2] = tbl[0] ^ (16'h1 << $urandom_range(15, 0)); end
      sel = it[0];
      exp_edge = sel ? 17 : 33;
      sweep(sel, exp_edge + 1, -1, -1, de, pu, vb);
      checks++; if (de !== exp_edge || pu !== 1 || vb !== 0) begin errors++; $display("FAIL rnd%0d_timing got edge %0d pulses %0d badvec %0d exp %0d 1 0", it, de, pu, vb, exp_edge); end
      checks++; if ((sel ? tt_b : tt_a) !== model_tt()) begin errors++; $display("FAIL rnd%0d_tt got %h exp %h", it, sel ? tt_b : tt_a, model_tt()); end
      checks++; if ((sel ? mm_b : mm_a) !== model_mm()) begin errors++; $display("FAIL rnd%0d_mm got %h exp %h", it, sel ? mm_b : mm_a, model_mm()); end
      checks++; if ((sel ? ec_b : ec_a) !== model_err()) begin errors++; $display("FAIL rnd%0d_err got %0d exp %0d", it, sel ? ec_b : ec_a, model_err()); end
      checks++; if ((sel ? eq_b : eq_a) !== (model_err() == 0)) begin errors++; $display("FAIL rnd%0d_equiv got %b exp %b", it, sel ? eq_b : eq_a, model_err() == 0); end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) tbl[i] = '0;
    test_reset();
    test_all_equal();
    test_stuck();
    test_single_flip();
    test_back_to_back();
    test_mid_reset();
    test_settle0();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
